// File: rtl/ps2_matrix_kbd.sv
// PS/2 to key-matrix converter: events are buffered in a FIFO, translated through a
// run-time loadable scancode RAM and held in the matrix for a minimum time.
module ps2_matrix_kbd #(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int HOLD_W     = 20,
   parameter int MIN_HOLD   = 50000,
   parameter int SHIFT_ROW  = 6,
   parameter int SHIFT_COL  = 7
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic [10:0]     ps2_key,
   input  logic [COLS-1:0] addr,
   output logic [ROWS-1:0] kb_rows,
   input  logic            map_wr,
   input  logic [8:0]      map_addr,
   input  logic [10:0]     map_data,
   output logic [11:1]     Fn,
   output logic [2:0]      modif,
   output logic            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, WAIT} state_t;

   state_t                     state;
   logic                       toggle_q;
   logic                       primed;
   logic                       strobe;
   logic [9:0]                 fifo_mem [FIFO_DEPTH];
   logic [AW:0]                wr_ptr;
   logic [AW:0]                rd_ptr;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic                       pop;
   logic                       push;
   logic [9:0]                 head;
   logic [10:0]                map_ram [512];
   logic [10:0]                ram_q;
   logic [9:0]                 evt_q;
   logic [HOLD_W-1:0]          hold_cnt;
   logic [ROWS-1:0][COLS-1:0]  matrix;
   logic [ROWS-1:0][COLS-1:0]  matrix_eff;
   logic [ROWS-1:0][COLS-1:0]  cell_hit;
   logic                       phys_shift;
   logic                       force_f;
   logic                       supp_f;

   logic                       evt_ext;
   logic [7:0]                 evt_code;
   logic                       evt_pr;
   logic                       ent_valid;
   logic                       ent_force;
   logic                       ent_supp;
   logic [3:0]                 ent_row;
   logic [3:0]                 ent_col;
   logic                       ent_ok;
   logic                       is_shift_code;
   logic                       hold_done;

   // The first cycle after reset only captures the toggle bit, so a stale level is not an event.
   assign strobe = primed & (ps2_key[10] ^ toggle_q);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q <= 1'b0;
         primed   <= 1'b0;
      end else begin
         toggle_q <= ps2_key[10];
         primed   <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         Fn    <= '0;
         modif <= '0;
      end else if (strobe) begin
         case (ps2_key[7:0])
            8'h05:   Fn[1]    <= ps2_key[9];
            8'h06:   Fn[2]    <= ps2_key[9];
            8'h04:   Fn[3]    <= ps2_key[9];
            8'h0C:   Fn[4]    <= ps2_key[9];
            8'h03:   Fn[5]    <= ps2_key[9];
            8'h0B:   Fn[6]    <= ps2_key[9];
            8'h83:   Fn[7]    <= ps2_key[9];
            8'h0A:   Fn[8]    <= ps2_key[9];
            8'h01:   Fn[9]    <= ps2_key[9];
            8'h09:   Fn[10]   <= ps2_key[9];
            8'h78:   Fn[11]   <= ps2_key[9];
            8'h14:   modif[2] <= ps2_key[9];
            8'h11:   modif[1] <= ps2_key[9];
            8'h59:   modif[0] <= ps2_key[9];
            default: ;
         endcase
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = (state == IDLE) && !fifo_empty;
   assign push       = strobe && (!fifo_full || pop);
   assign head       = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (strobe && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {ps2_key[8], ps2_key[7:0], ps2_key[9]};
   end

   // Mapping RAM is never reset; a lookup concurrent with a write sees the old entry.
   always_ff @(posedge clk_sys) begin
      if (map_wr) map_ram[map_addr] <= map_data;
      if (pop) ram_q <= map_ram[head[9:1]];
   end

   assign evt_ext       = evt_q[9];
   assign evt_code      = evt_q[8:1];
   assign evt_pr        = evt_q[0];
   assign ent_valid     = ram_q[10];
   assign ent_force     = ram_q[9];
   assign ent_supp      = ram_q[8];
   assign ent_row       = ram_q[7:4];
   assign ent_col       = ram_q[3:0];
   assign ent_ok        = ent_valid && (int'(ent_row) < ROWS) && (int'(ent_col) < COLS);
   assign is_shift_code = !evt_ext && ((evt_code == 8'h12) || (evt_code == 8'h59));
   // The counter hits zero at the end of this cycle, which keeps a short tap visible for exactly MIN_HOLD cycles.
   assign hold_done     = (hold_cnt <= HOLD_W'(1));

   always_comb begin
      cell_hit = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            cell_hit[r][c] = (int'(ent_row) == r) && (int'(ent_col) == c);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         evt_q      <= '0;
         hold_cnt   <= '0;
         matrix     <= '1;
         phys_shift <= 1'b0;
         force_f    <= 1'b0;
         supp_f     <= 1'b0;
      end else begin
         if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  evt_q <= head;
                  state <= LOOKUP;
               end
            end
            LOOKUP: state <= APPLY;
            APPLY: begin
               state <= IDLE;
               if (is_shift_code) begin
                  phys_shift <= evt_pr;
               end else if (ent_ok) begin
                  if (evt_pr) begin
                     matrix   <= matrix & ~cell_hit;
                     hold_cnt <= HOLD_W'(MIN_HOLD);
                     if (ent_force) force_f <= 1'b1;
                     if (ent_supp) supp_f <= 1'b1;
                  end else if (!hold_done) begin
                     state <= WAIT;
                  end else begin
                     matrix <= matrix | cell_hit;
                     if (ent_force) force_f <= 1'b0;
                     if (ent_supp) supp_f <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (hold_cnt <= HOLD_W'(2)) state <= APPLY;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      matrix_eff = matrix;
      matrix_eff[SHIFT_ROW][SHIFT_COL] = ~((phys_shift & ~supp_f) | force_f);
   end

   always_comb begin
      kb_rows = '1;
      for (int r = 0; r < ROWS; r++) begin
         kb_rows[r] = &(addr | matrix_eff[r]);
      end
   end

endmodule
